// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data access.
// Data wins by default; a fetch that has waited STARVE_LIMIT data grants is granted next.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RESP} state_t;

    state_t        state_q, state_d;
    logic          gnt_d_q, gnt_d_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [2:0]    starve_q, starve_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          err_q, err_d;

    always_comb begin
        state_d    = state_q;
        gnt_d_d    = gnt_d_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        f3_d       = f3_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (d_req && !(if_req && starve_q == 3'(STARVE_LIMIT))) begin
                    state_d = BUSY_D;
                    gnt_d_d = 1'b1;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    we_d    = d_we;
                    f3_d    = d_funct3;
                    wait_d  = '0;
                    // Count only grants that bypassed a waiting fetch
                    if (!if_req)
                        starve_d = '0;
                    else if (starve_q < 3'(STARVE_LIMIT))
                        starve_d = starve_q + 3'd1;
                end else if (if_req) begin
                    state_d  = BUSY_I;
                    gnt_d_d  = 1'b0;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    we_d     = 1'b0;
                    f3_d     = 3'b010;
                    wait_d   = '0;
                    starve_d = '0;
                end
            end
            BUSY_D, BUSY_I: begin
                if (mem_ready) begin
                    state_d = RESP;
                    if (gnt_d_q) d_rdata_d  = mem_rdata;
                    else         if_rdata_d = mem_rdata;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_d == WW'(MAX_WAIT)) begin
                        // Abort: complete the transaction with zero data and flag it
                        state_d = RESP;
                        err_d   = 1'b1;
                        if (gnt_d_q) d_rdata_d  = '0;
                        else         if_rdata_d = '0;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_d_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            starve_q   <= '0;
            wait_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_d_q    <= gnt_d_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    assign mem_req    = (state_q == BUSY_D) || (state_q == BUSY_I);
    assign mem_we     = we_q && (state_q == BUSY_D);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_funct3 = f3_q;
    assign if_valid   = (state_q == RESP) && !gnt_d_q;
    assign d_valid    = (state_q == RESP) && gnt_d_q;
    assign if_rdata   = if_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign err        = err_q;
    assign stall_if   = if_req && !if_valid;
    assign stall_mem  = d_req && !d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation, timeout,
// address stability and asynchronous reset mid-transaction.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [2:0]  d_funct3;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall_if, stall_mem, err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    task automatic test_reset();
        rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_funct3 = 0; mem_ready = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_req, mem_we, if_valid, d_valid, err, stall_if, stall_mem} !== 7'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_funct3 !== 3'b0 ||
            if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: mem_req=%b addr=%h if_rdata=%h d_rdata=%h err=%b, required all 0",
                     mem_req, mem_addr, if_rdata, d_rdata, err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1 || mem_we !== 0 || mem_addr !== 32'h100 || mem_funct3 !== 3'b010 || stall_if !== 1) begin
            n_bad++;
            $display("FAIL fetch_busy: req=%b we=%b addr=%h f3=%b stall_if=%b, required 1 0 00000100 010 1",
                     mem_req, mem_we, mem_addr, mem_funct3, stall_if);
        end
        mem_ready = 1; mem_rdata = 32'h00500093;
        @(negedge clk);
        n_cmp++;
        if (if_valid !== 1 || if_rdata !== 32'h00500093 || stall_if !== 0 || mem_req !== 0) begin
            n_bad++;
            $display("FAIL fetch_resp: valid=%b rdata=%h stall_if=%b mem_req=%b, required 1 00500093 0 0",
                     if_valid, if_rdata, stall_if, mem_req);
        end
        if_req = 0; mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_cmp++;
        if (if_valid !== 0 || if_rdata !== 32'h00500093 || mem_req !== 0) begin
            n_bad++;
            $display("FAIL fetch_after: valid=%b rdata=%h mem_req=%b, required 0 00500093 0",
                     if_valid, if_rdata, mem_req);
        end
    endtask

    task automatic test_contention();
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1 || mem_we !== 1 || mem_addr !== 32'h2000 || mem_wdata !== 32'hDEADBEEF ||
            stall_if !== 1 || stall_mem !== 1) begin
            n_bad++;
            $display("FAIL store_first: we=%b addr=%h wdata=%h stall_if=%b stall_mem=%b, required 1 00002000 deadbeef 1 1",
                     mem_we, mem_addr, mem_wdata, stall_if, stall_mem);
        end
        mem_ready = 1; mem_rdata = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (d_valid !== 1 || if_valid !== 0 || stall_if !== 1 || stall_mem !== 0) begin
            n_bad++;
            $display("FAIL store_resp: d_valid=%b if_valid=%b stall_if=%b stall_mem=%b, required 1 0 1 0",
                     d_valid, if_valid, stall_if, stall_mem);
        end
        d_req = 0; d_we = 0; mem_ready = 0;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 0 || stall_if !== 1) begin
            n_bad++;
            $display("FAIL contention_idle: mem_req=%b stall_if=%b, required 0 1", mem_req, stall_if);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1 || mem_we !== 0 || mem_addr !== 32'h200 || mem_funct3 !== 3'b010 || stall_if !== 1) begin
            n_bad++;
            $display("FAIL fetch_second: req=%b we=%b addr=%h f3=%b stall_if=%b, required 1 0 00000200 010 1",
                     mem_req, mem_we, mem_addr, mem_funct3, stall_if);
        end
        mem_ready = 1; mem_rdata = 32'h00000013;
        @(negedge clk);
        n_cmp++;
        if (if_valid !== 1 || if_rdata !== 32'h00000013) begin
            n_bad++;
            $display("FAIL fetch_second_resp: valid=%b rdata=%h, required 1 00000013", if_valid, if_rdata);
        end
        if_req = 0; mem_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_starve();
        if_req = 1; if_addr = 32'h300;
        d_req = 1; d_we = 0; d_addr = 32'h1000; d_funct3 = 3'b000;
        for (int i = 0; i < 5; i++) begin
            logic        exp_d;
            logic [31:0] exp_addr;
            logic [2:0]  exp_cnt;
            exp_d    = (i < 4);
            exp_addr = exp_d ? 32'h1000 : 32'h300;
            exp_cnt  = exp_d ? 3'(i + 1) : 3'd0;
            @(negedge clk);
            n_cmp++;
            if (mem_req !== 1 || mem_addr !== exp_addr || dut.starve_q !== exp_cnt) begin
                n_bad++;
                $display("FAIL starve_grant%0d: mem_req=%b addr=%h cnt=%0d, required 1 %h %0d",
                         i, mem_req, mem_addr, dut.starve_q, exp_addr, exp_cnt);
            end
            mem_ready = 1; mem_rdata = 32'hA5A5_0000 + 32'(i);
            @(negedge clk);
            n_cmp++;
            if (d_valid !== exp_d || if_valid !== !exp_d) begin
                n_bad++;
                $display("FAIL starve_resp%0d: d_valid=%b if_valid=%b, required %b %b",
                         i, d_valid, if_valid, exp_d, !exp_d);
            end
            mem_ready = 0;
            @(negedge clk);
        end
        if_req = 0; d_req = 0;
        n_cmp++;
        if (dut.starve_q !== 3'd0 || d_rdata !== 32'hA5A5_0003 || if_rdata !== 32'hA5A5_0004) begin
            n_bad++;
            $display("FAIL starve_final: cnt=%0d d_rdata=%h if_rdata=%h, required 0 a5a50003 a5a50004",
                     dut.starve_q, d_rdata, if_rdata);
        end
    endtask

    task automatic test_timeout();
        int busy_bad;
        busy_bad = 0;
        d_req = 1; d_we = 0; d_addr = 32'h3000; mem_ready = 0; mem_rdata = 32'h1234_5678;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (mem_req !== 1 || d_valid !== 0 || err !== 0) busy_bad++;
        end
        n_cmp++;
        if (busy_bad != 0) begin
            n_bad++;
            $display("FAIL timeout_busy: %0d of 15 busy cycles wrong (mem_req/d_valid/err), required 0", busy_bad);
        end
        @(negedge clk);
        n_cmp++;
        if (d_valid !== 1 || d_rdata !== 32'h0 || err !== 1 || mem_req !== 0) begin
            n_bad++;
            $display("FAIL timeout_resp: d_valid=%b d_rdata=%h err=%b mem_req=%b, required 1 00000000 1 0",
                     d_valid, d_rdata, err, mem_req);
        end
        d_req = 0;
        @(negedge clk);
        n_cmp++;
        if (d_valid !== 0 || err !== 1) begin
            n_bad++;
            $display("FAIL timeout_sticky: d_valid=%b err=%b, required 0 1", d_valid, err);
        end
    endtask

    task automatic test_stable();
        int unstable;
        unstable = 0;
        d_req = 1; d_we = 1; d_addr = 32'h4000; d_wdata = 32'h1234_5678; d_funct3 = 3'b001;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_req !== 1 || mem_addr !== 32'h4000 || mem_wdata !== 32'h1234_5678 ||
                mem_funct3 !== 3'b001 || mem_we !== 1) unstable++;
            d_addr = 32'h8000 + 32'(k * 4); d_wdata = ~d_wdata;
            if (k == 5) mem_ready = 1;
        end
        n_cmp++;
        if (unstable != 0) begin
            n_bad++;
            $display("FAIL stable_busy: %0d of 6 busy cycles showed changed mem_* outputs, required 0", unstable);
        end
        @(negedge clk);
        n_cmp++;
        if (d_valid !== 1 || err !== 1) begin
            n_bad++;
            $display("FAIL stable_resp: d_valid=%b err=%b, required 1 1", d_valid, err);
        end
        d_req = 0; d_we = 0; mem_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 1; d_addr = 32'h5000; d_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1 || mem_addr !== 32'h5000) begin
            n_bad++;
            $display("FAIL reset_mid_busy: mem_req=%b addr=%h, required 1 00005000", mem_req, mem_addr);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            err !== 0 || d_valid !== 0 || d_rdata !== 32'h0 || if_rdata !== 32'h0 || dut.state_q !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_async: mem_req=%b addr=%h err=%b d_rdata=%h state=%0d, required all 0",
                     mem_req, mem_addr, err, d_rdata, dut.state_q);
        end
        d_req = 0; d_we = 0;
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1; mem_rdata = 32'h7777_7777;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (d_valid !== 0 || if_valid !== 0 || mem_req !== 0 || d_rdata !== 32'h0 || dut.state_q !== 2'b00) begin
                n_bad++;
                $display("FAIL late_ready: d_valid=%b if_valid=%b mem_req=%b d_rdata=%h, required 0 0 0 00000000",
                         d_valid, if_valid, mem_req, d_rdata);
            end
        end
        mem_ready = 0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_starve();
        test_timeout();
        test_stable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits.
REQ-002 Parameter: MAX_WAIT, 15, busy cycles without mem_ready before a transaction is aborted.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  reset is asynchronous and active-low.
REQ-005 if_req  in  1  fetch stage requests an instruction read.
REQ-006 if_addr  in  32  fetch address.
REQ-007 if_rdata  out  32  returned instruction word.
REQ-008 if_valid  out  1  one-cycle completion pulse for fetch.
REQ-009 d_req / d_we  in  1 / 1  memory-stage request and write enable.
REQ-010 d_addr / d_wdata  in  32 / 32  data address and store data.
REQ-011 d_funct3  in  3  access size/sign code, forwarded unchanged.
REQ-012 d_rdata / d_valid  out  32 / 1  load data and one-cycle completion pulse.
REQ-013 mem_req / mem_we  out  1 / 1  shared memory port request and write enable.
REQ-014 mem_addr / mem_wdata  out  32 / 32  shared port address and write data.
REQ-015 mem_funct3  out  3  size code; 3'b010 for instruction fetches.
REQ-016 mem_ready / mem_rdata  in  1 / 32  memory completion and read data.
REQ-017 stall_if / stall_mem  out  1 / 1  pipeline stall requests.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, BUSY_D, BUSY_I, RESP.
REQ-020 In IDLE, d_req=1 SHALL move to BUSY_D unless if_req=1 and the starvation count equals STARVE_LIMIT, in which case it SHALL move to BUSY_I.
REQ-021 In IDLE, if_req=1 with d_req=0 SHALL move to BUSY_I; no request SHALL stay in IDLE.
REQ-022 On grant, address, write data, write enable and funct3 SHALL be latched; mem_* outputs SHALL be driven only from latched values and held stable for the whole busy state.
REQ-023 mem_req SHALL be 1 exactly in BUSY_D and BUSY_I; mem_we SHALL be 0 in BUSY_I.
REQ-024 In a busy state, mem_ready=1 SHALL register mem_rdata into the granted side's rdata and move to RESP.
REQ-025 In RESP, the granted side's valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-026 Minimum latency SHALL be: grant edge, one busy cycle, RESP cycle, giving valid 2 cycles after the request is sampled.
REQ-027 Requests SHALL NOT be sampled in BUSY_* or RESP; a requester holds req until valid.
REQ-028 A req that drops mid-transaction SHALL NOT cancel it; the transaction completes and valid still pulses.
REQ-029 The 3-bit starvation counter SHALL increment on each data grant made while if_req=1.
REQ-030 The counter SHALL clear on every instruction grant, and on any data grant made while if_req=0.
REQ-031 The counter SHALL saturate at STARVE_LIMIT.
REQ-032 A busy-cycle counter SHALL clear on grant and increment each busy cycle with mem_ready=0.
REQ-033 When the busy-cycle counter reaches MAX_WAIT, the FSM SHALL move to RESP with rdata=0, set err, and drop mem_req.
REQ-034 err SHALL remain set until reset.
REQ-035 mem_ready asserted outside the busy states SHALL be ignored.
REQ-036 stall_if SHALL equal if_req AND NOT if_valid.
REQ-037 stall_mem SHALL equal d_req AND NOT d_valid.
REQ-038 if_rdata and d_rdata SHALL hold their last value until overwritten by that side's next completion.

Reset
REQ-039 reset=0 SHALL immediately force IDLE and clear both counters and all outputs to 0 (err, valids, rdatas, mem_*), including mid-transaction.
REQ-040 The first grant SHALL occur on the first clk edge after reset release with a pending request.

Verification
REQ-041 Lone fetch if_req=1, if_addr=0x100, memory ready in first busy cycle with 0x00500093 -> mem_addr=0x100, mem_funct3=3'b010; if_valid pulses 2 cycles after the sampling edge with if_rdata=0x00500093.
REQ-042 Simultaneous if_req and d_req (d_we=1, addr 0x2000, wdata 0xDEADBEEF) -> store granted first with mem_we=1; fetch granted on the next IDLE; stall_if=1 throughout.
REQ-043 if_req held high with d_req back-to-back -> after 4 data grants the fifth arbitration grants fetch; the counter then reads 0.
REQ-044 mem_ready held 0 -> after 15 busy cycles d_valid pulses with d_rdata=0, err=1 and stays 1.
REQ-045 reset driven low during BUSY_D with 3-cycle memory latency -> mem_req=0, state IDLE, outputs 0 without a clock edge; a late mem_ready is ignored.
REQ-046 Memory ready after 5 wait cycles with mem_addr changing on input -> mem_addr/mem_wdata remain stable across all busy cycles.
